sync_fifo_fwft: RTL and testbench
=================================

// Module: sync_fifo_fwft
// PURPOSE
// - Single-clock FIFO for same-domain buffering between producer and consumer pipelines.
// - Parametrised successor of the dual-clock FIFO; drops pointer synchronisers.
// - Adds: selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty,
//   fill-level output, sticky overflow/underflow error flags.
// PARAMETERS
// - DWIDTH     8   data word width (>=1)
// - DEPTH      16  entries; power of two, >=2
// - FWFT       0   0 = registered read (data 1 cycle after r_en); 1 = head word presented on rdata
// - AFULL_LVL  14  wafull asserts when level >= AFULL_LVL (1..DEPTH)
// - AEMPTY_LVL 2   raempty asserts when level <= AEMPTY_LVL (0..DEPTH-1)
// PORTS
// - clk        in   1                  single clock, rising edge
// - rst        in   1                  asynchronous, active-high reset
// - w_en       in   1                  write request
// - wdata      in   DWIDTH             write data
// - wfull      out  1                  level == DEPTH
// - wafull     out  1                  level >= AFULL_LVL
// - r_en       in   1                  read/pop request
// - rdata      out  DWIDTH             read data (timing per FWFT)
// - rempty     out  1                  level == 0
// - raempty    out  1                  level <= AEMPTY_LVL
// - level      out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// - overflow   out  1                  sticky: write attempted while full
// - underflow  out  1                  sticky: read attempted while empty
// - clr_err    in   1                  synchronous clear of overflow/underflow
// BEHAVIOUR
// - Reset (async, immediate): wptr=rptr=0, level=0, rempty=1, raempty=1, wfull=0, wafull=0,
//   overflow=underflow=0, rdata=0. Storage array is not reset.
// - Accepted write: w_en && !wfull. Accepted read: r_en && !rempty. Rejected requests change no state.
// - Pointers: AWIDTH=$clog2(DEPTH) bits, wrap DEPTH-1 -> 0 by natural overflow.
// - level: +1 on write-only, -1 on read-only, unchanged on both or neither; registered.
// - All four flags decode from the registered level only; no combinational path from w_en/r_en.
// - Simultaneous read+write while full: read accepted, write rejected (wfull was 1), overflow set.
// - Simultaneous read+write while empty: write accepted, read rejected, underflow set.
// - Simultaneous on partial level: both accepted, level unchanged; rdata is the old head, never wdata.
// - Write->rempty deassert latency: 1 cycle (next edge after accepted write).
// - FWFT=0: rdata registered; loads mem[rptr] on the accepted-read edge, else holds.
// - FWFT=1: rdata = mem[rptr] combinationally, valid whenever rempty==0. r_en pops the head;
//   the next word appears the same cycle. Contents when rempty==1 are don't-care.
// - overflow set by w_en&&wfull; underflow set by r_en&&rempty. clr_err clears both.
//   If set and clear occur in the same cycle, set wins.
// - Elaboration check ($error): DEPTH not a power of two, or thresholds out of range.
// STRUCTURE
// - Package sync_fifo_pkg holds the level-width function lvl_w(depth)=$clog2(depth)+1 and
//   the threshold range-check function, shared with the dual-clock FIFO's next revision.
// - Sub-module fifo_mem_2p: DEPTH x DWIDTH register array, one synchronous write port,
//   one combinational read port. Top holds pointers, level, flags, FWFT mux/register.
// TESTING
// - Reset, then write 0xA1,0xB2,0xC3 (FWFT=0), read 3 -> rdata A1,B2,C3 one cycle after each r_en.
//   level 3->0; rempty=1 after last pop.
// - FWFT=1: single write 0x5C to empty -> next cycle rempty=0, rdata=0x5C without r_en.
//   One r_en -> rempty=1.
// - Fill 16 (DEPTH=16) -> wfull=1, wafull from level 14, level=16. 17th write -> overflow=1,
//   contents intact; drain returns 16 words in order across pointer wrap.
// - Full + w_en&r_en same cycle -> one word popped, write rejected, level=15, overflow=1.
//   Empty + w_en&r_en -> level=1, underflow=1.
// - Assert rst mid-stream at level 7 -> same edge-independent clear: level=0, rempty=1, rdata=0;
//   subsequent write/read works from pointer 0.
// - clr_err coinciding with a new overflow event -> overflow stays 1; clr_err alone -> 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing and parameter-legality helpers for the single- and dual-clock FIFOs.
// Pure elaboration-time functions; no logic, latency or flow control of their own.
package sync_fifo_pkg;

  // Occupancy needs one more bit than the pointers so that "full" (== depth) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int afull_lvl, input int aempty_lvl);
    return (afull_lvl >= 1) && (afull_lvl <= depth) &&
           (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DWIDTH register array: write lands on the clock edge, read is combinational (0 cycles).
// No flow control here; the caller gates the write enable.
module fifo_mem_2p #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through; rdata 1 cycle after r_en (FWFT=0) or 0 (FWFT=1).
// Writes while full and reads while empty are dropped and recorded in sticky overflow/underflow flags.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b0,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [DWIDTH-1:0]         wdata,
  output logic                      wfull,
  output logic                      wafull,
  input  logic                      r_en,
  output logic [DWIDTH-1:0]         rdata,
  output logic                      rempty,
  output logic                      raempty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int AWIDTH = $clog2(DEPTH);
  localparam int LW     = lvl_w(DEPTH);

  localparam logic [LW-1:0] FULL_L   = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH=%0d is not a power of two >= 2", DEPTH);
  end
  if (!thresholds_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_thresh
    $error("sync_fifo_fwft: AFULL_LVL=%0d / AEMPTY_LVL=%0d out of range for DEPTH=%0d",
           AFULL_LVL, AEMPTY_LVL, DEPTH);
  end

  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [DWIDTH-1:0] mem_rd;
  logic              wr_fire;
  logic              rd_fire;

  // Flags come only from the registered level, so request inputs never reach them combinationally.
  assign wfull   = (level == FULL_L);
  assign wafull  = (level >= AFULL_L);
  assign rempty  = (level == '0);
  assign raempty = (level <= AEMPTY_L);

  assign wr_fire = w_en && !wfull;
  assign rd_fire = r_en && !rempty;

  fifo_mem_2p #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk    (clk),
    .we     (wr_fire),
    .waddr  (wptr),
    .wdata  (wdata),
    .raddr  (rptr),
    .rdata  (mem_rd)
  );

  // Pointers wrap DEPTH-1 -> 0 through natural overflow of their AWIDTH bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_fire) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_fire) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && wfull) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (r_en && rempty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata = mem_rd;
  end else begin : g_reg_rd
    logic [DWIDTH-1:0] rdata_q;

    // mem_rd is the pre-edge head, so a same-cycle write can never leak into rdata.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_fire) begin
        rdata_q <= mem_rd;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: registered-read and FWFT instances checked against queue models.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          w_en0, r_en0, clr0, wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
  logic [DW-1:0] wdata0, rdata0;
  logic [LW-1:0] level0;
  logic          w_en1, r_en1, clr1, wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
  logic [DW-1:0] wdata1, rdata1;
  logic [LW-1:0] level1;

  sync_fifo_fwft #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en0), .wdata(wdata0), .wfull(wfull0), .wafull(wafull0),
    .r_en(r_en0), .rdata(rdata0), .rempty(rempty0), .raempty(raempty0), .level(level0),
    .overflow(ovf0), .underflow(unf0), .clr_err(clr0));

  sync_fifo_fwft #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en1), .wdata(wdata1), .wfull(wfull1), .wafull(wafull1),
    .r_en(r_en1), .rdata(rdata1), .rempty(rempty1), .raempty(raempty1), .level(level1),
    .overflow(ovf1), .underflow(unf1), .clr_err(clr1));

  int tests_run = 0;
  int fails     = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp_rd0;
  bit            exp_ovf0, exp_unf0;

  // One clock of stimulus on the registered-read instance, with the queue model advanced to match.
  task automatic step0(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit full, empty;
    full  = (q0.size() == DEPTH);
    empty = (q0.size() == 0);
    w_en0 = w; wdata0 = d; r_en0 = r; clr0 = c;
    @(posedge clk); #1;
    if (r && !empty) exp_rd0 = q0.pop_front();
    if (w && !full) q0.push_back(d);
    if (w && full) exp_ovf0 = 1'b1; else if (c) exp_ovf0 = 1'b0;
    if (r && empty) exp_unf0 = 1'b1; else if (c) exp_unf0 = 1'b0;
    w_en0 = 1'b0; r_en0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic step1(input bit w, input logic [DW-1:0] d, input bit r);
    bit full, empty;
    full  = (q1.size() == DEPTH);
    empty = (q1.size() == 0);
    w_en1 = w; wdata1 = d; r_en1 = r;
    @(posedge clk); #1;
    if (r && !empty) void'(q1.pop_front());
    if (w && !full) q1.push_back(d);
    w_en1 = 1'b0; r_en1 = 1'b0;
  endtask

  task automatic clear_models();
    q0.delete(); q1.delete();
    exp_rd0 = '0; exp_ovf0 = 1'b0; exp_unf0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    clear_models();
    tests_run++; if (level0 !== '0) begin fails++; $display("FAIL reset_level got %0d want 0", level0); end
    tests_run++; if ({rempty0, raempty0, wfull0, wafull0} !== 4'b1100) begin fails++; $display("FAIL reset_flags got %b want 1100", {rempty0, raempty0, wfull0, wafull0}); end
    tests_run++; if ({ovf0, unf0} !== 2'b00) begin fails++; $display("FAIL reset_err got %b want 00", {ovf0, unf0}); end
    tests_run++; if (rdata0 !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", rdata0); end
    tests_run++; if ({level1, rempty1} !== {LW'(0), 1'b1}) begin fails++; $display("FAIL reset_fwft level=%0d rempty=%b want 0/1", level1, rempty1); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    for (int i = 0; i < 3; i++) step0(1'b1, words[i], 1'b0, 1'b0);
    tests_run++; if (level0 !== LW'(3)) begin fails++; $display("FAIL basic_level got %0d want 3", level0); end
    tests_run++; if (rempty0 !== 1'b0) begin fails++; $display("FAIL basic_rempty got %b want 0", rempty0); end
    for (int i = 0; i < 3; i++) begin
      step0(1'b0, '0, 1'b1, 1'b0);
      tests_run++; if (rdata0 !== words[i]) begin fails++; $display("FAIL basic_rdata[%0d] got %h want %h", i, rdata0, words[i]); end
      tests_run++; if (level0 !== LW'(2 - i)) begin fails++; $display("FAIL basic_drain_level got %0d want %0d", level0, 2 - i); end
    end
    tests_run++; if (rempty0 !== 1'b1) begin fails++; $display("FAIL basic_empty got %b want 1", rempty0); end
    step0(1'b0, '0, 1'b0, 1'b0);
    tests_run++; if (rdata0 !== 8'hC3) begin fails++; $display("FAIL basic_hold got %h want c3", rdata0); end
  endtask

  task automatic test_fwft();
    step1(1'b1, 8'h5C, 1'b0);
    tests_run++; if (rempty1 !== 1'b0) begin fails++; $display("FAIL fwft_rempty got %b want 0", rempty1); end
    tests_run++; if (rdata1 !== 8'h5C) begin fails++; $display("FAIL fwft_rdata got %h want 5c", rdata1); end
    step1(1'b0, '0, 1'b1);
    tests_run++; if (rempty1 !== 1'b1) begin fails++; $display("FAIL fwft_pop_empty got %b want 1", rempty1); end
    for (int i = 0; i < 5; i++) step1(1'b1, DW'($urandom), 1'b0);
    while (q1.size() > 0) begin
      tests_run++; if (rdata1 !== q1[0]) begin fails++; $display("FAIL fwft_head got %h want %h", rdata1, q1[0]); end
      step1(1'b0, '0, 1'b1);
    end
    tests_run++; if ({rempty1, level1} !== {1'b1, LW'(0)}) begin fails++; $display("FAIL fwft_drained rempty=%b level=%0d", rempty1, level1); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step0(1'b1, DW'($urandom), 1'b0, 1'b0);
      tests_run++; if (wafull0 !== (i >= AF)) begin fails++; $display("FAIL fill_wafull at %0d got %b want %b", i, wafull0, i >= AF); end
      tests_run++; if (wfull0 !== (i == DEPTH)) begin fails++; $display("FAIL fill_wfull at %0d got %b want %b", i, wfull0, i == DEPTH); end
    end
    tests_run++; if (level0 !== LW'(DEPTH)) begin fails++; $display("FAIL fill_level got %0d want %0d", level0, DEPTH); end
    step0(1'b1, 8'hEE, 1'b0, 1'b0);
    tests_run++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL fill_overflow got %b want 1", ovf0); end
    tests_run++; if (level0 !== LW'(DEPTH)) begin fails++; $display("FAIL fill_ovf_level got %0d want %0d", level0, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      step0(1'b0, '0, 1'b1, 1'b0);
      tests_run++; if (rdata0 !== exp_rd0) begin fails++; $display("FAIL fill_drain[%0d] got %h want %h", i, rdata0, exp_rd0); end
    end
    tests_run++; if (rempty0 !== 1'b1) begin fails++; $display("FAIL fill_drained got %b want 1", rempty0); end
  endtask

  task automatic test_simul_full_empty();
    logic [DW-1:0] first;
    step0(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step0(1'b1, DW'($urandom), 1'b0, 1'b0);
    first = q0[0];
    step0(1'b1, 8'h77, 1'b1, 1'b0);
    tests_run++; if (level0 !== LW'(DEPTH - 1)) begin fails++; $display("FAIL full_rw_level got %0d want %0d", level0, DEPTH - 1); end
    tests_run++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL full_rw_overflow got %b want 1", ovf0); end
    tests_run++; if (rdata0 !== first) begin fails++; $display("FAIL full_rw_rdata got %h want %h", rdata0, first); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      step0(1'b0, '0, 1'b1, 1'b0);
      tests_run++; if (rdata0 !== exp_rd0) begin fails++; $display("FAIL full_rw_drain got %h want %h", rdata0, exp_rd0); end
    end
    step0(1'b1, 8'h99, 1'b1, 1'b0);
    tests_run++; if (level0 !== LW'(1)) begin fails++; $display("FAIL empty_rw_level got %0d want 1", level0); end
    tests_run++; if (unf0 !== 1'b1) begin fails++; $display("FAIL empty_rw_underflow got %b want 1", unf0); end
    step0(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (rdata0 !== 8'h99) begin fails++; $display("FAIL empty_rw_pop got %h want 99", rdata0); end
  endtask

  task automatic test_partial_rw();
    logic [DW-1:0] head;
    step0(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step0(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    head = q0[0];
    step0(1'b1, 8'h42, 1'b1, 1'b0);
    tests_run++; if (level0 !== LW'(5)) begin fails++; $display("FAIL partial_level got %0d want 5", level0); end
    tests_run++; if (rdata0 !== head) begin fails++; $display("FAIL partial_rdata got %h want %h", rdata0, head); end
    tests_run++; if ({ovf0, unf0} !== 2'b00) begin fails++; $display("FAIL partial_err got %b want 00", {ovf0, unf0}); end
    while (q0.size() > 0) begin
      step0(1'b0, '0, 1'b1, 1'b0);
      tests_run++; if (rdata0 !== exp_rd0) begin fails++; $display("FAIL partial_drain got %h want %h", rdata0, exp_rd0); end
    end
  endtask

  task automatic test_clr_err();
    step0(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (unf0 !== 1'b1) begin fails++; $display("FAIL clr_unf_set got %b want 1", unf0); end
    for (int i = 0; i < DEPTH; i++) step0(1'b1, DW'($urandom), 1'b0, 1'b0);
    step0(1'b1, 8'hAB, 1'b0, 1'b1);
    tests_run++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL clr_set_wins got %b want 1", ovf0); end
    tests_run++; if (unf0 !== 1'b0) begin fails++; $display("FAIL clr_unf_cleared got %b want 0", unf0); end
    step0(1'b0, '0, 1'b0, 1'b1);
    tests_run++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL clr_alone got %b want 0", ovf0); end
    while (q0.size() > 0) step0(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int pw;
    for (int n = 0; n < 600; n++) begin
      pw = (n < 200) ? 75 : (n < 400) ? 25 : 50;
      step0($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 19) == 0);
      tests_run++;
      if (level0 !== LW'(q0.size()) || rdata0 !== exp_rd0 || ovf0 !== exp_ovf0 || unf0 !== exp_unf0 ||
          wfull0 !== (q0.size() == DEPTH) || wafull0 !== (q0.size() >= AF) ||
          rempty0 !== (q0.size() == 0) || raempty0 !== (q0.size() <= AE)) begin
        fails++;
        $display("FAIL random cyc %0d got lvl=%0d rd=%h ov=%b un=%b f=%b af=%b e=%b ae=%b want lvl=%0d rd=%h ov=%b un=%b",
                 n, level0, rdata0, ovf0, unf0, wfull0, wafull0, rempty0, raempty0,
                 q0.size(), exp_rd0, exp_ovf0, exp_unf0);
      end
    end
  endtask

  task automatic test_midstream_reset();
    step0(1'b0, '0, 1'b0, 1'b1);
    while (q0.size() > 0) step0(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step0(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    step0(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (level0 !== LW'(7)) begin fails++; $display("FAIL mid_pre_level got %0d want 7", level0); end
    #1 rst = 1'b1;
    #1;
    clear_models();
    tests_run++; if (level0 !== '0) begin fails++; $display("FAIL mid_level got %0d want 0", level0); end
    tests_run++; if (rempty0 !== 1'b1) begin fails++; $display("FAIL mid_rempty got %b want 1", rempty0); end
    tests_run++; if (rdata0 !== 8'h00) begin fails++; $display("FAIL mid_rdata got %h want 00", rdata0); end
    #1 rst = 1'b0;
    step0(1'b1, 8'h3C, 1'b0, 1'b0);
    step0(1'b1, 8'h4D, 1'b0, 1'b0);
    step0(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (rdata0 !== 8'h3C) begin fails++; $display("FAIL mid_after_rdata got %h want 3c", rdata0); end
    tests_run++; if (level0 !== LW'(1)) begin fails++; $display("FAIL mid_after_level got %0d want 1", level0); end
  endtask

  initial begin
    w_en0 = 1'b0; r_en0 = 1'b0; clr0 = 1'b0; wdata0 = '0;
    w_en1 = 1'b0; r_en1 = 1'b0; clr1 = 1'b0; wdata1 = '0;
    test_reset();
    test_basic();
    test_fwft();
    test_fill();
    test_simul_full_empty();
    test_partial_rw();
    test_clr_err();
    test_random();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
